// File: rtl/irq_cond.sv
// Interrupt line conditioner: polarity normalisation, level passthrough or
// stretched edge pulses, sticky overrun flags. Optional filter: IRQ_COND_GLITCH_FILTER_EN.
module irq_cond #(
    parameter int unsigned NUM_IRQ   = 8,
    parameter logic [31:0] EDGE_MASK = 32'h0,
    parameter logic [31:0] POL_MASK  = 32'h0,
    parameter int unsigned STRETCH   = 4
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               en_i,
    input  logic [NUM_IRQ-1:0] ovr_clr_i,
    output logic [NUM_IRQ-1:0] irq_o,
    output logic [NUM_IRQ-1:0] overrun_o
);

    localparam int unsigned CW = 8;
    localparam logic [NUM_IRQ-1:0] EDGE_M    = EDGE_MASK[NUM_IRQ-1:0];
    localparam logic [NUM_IRQ-1:0] POL_M     = POL_MASK[NUM_IRQ-1:0];
    localparam logic [CW-1:0]      STRETCH_V = CW'(STRETCH);

    logic [NUM_IRQ-1:0] norm;
    logic [NUM_IRQ-1:0] s_src;
    logic [NUM_IRQ-1:0] upd;
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] s_d;
    logic [NUM_IRQ-1:0] s_ok;
    logic [NUM_IRQ-1:0] s_d_ok;
    logic [NUM_IRQ-1:0] s_nxt;
    logic [NUM_IRQ-1:0] edge_c;
    logic [NUM_IRQ-1:0] irq_nxt;
    logic [NUM_IRQ-1:0] ovr_nxt;
    logic [NUM_IRQ-1:0][CW-1:0] cnt;
    logic [NUM_IRQ-1:0][CW-1:0] cnt_nxt;

    assign norm = irq_i ^ POL_M;

`ifdef IRQ_COND_GLITCH_FILTER_EN
    logic [NUM_IRQ-1:0] f0;
    logic [NUM_IRQ-1:0] f1;
    logic [NUM_IRQ-1:0] f2;
    logic [1:0]         fill;

    // Three-sample shift; fill marks when all stages hold post-reset samples.
    always_ff @(posedge aclk) begin
        if (areset) begin
            f0   <= '0;
            f1   <= '0;
            f2   <= '0;
            fill <= 2'd0;
        end else begin
            f0 <= norm;
            f1 <= f0;
            f2 <= f1;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    assign s_src = f2;
    assign upd   = {NUM_IRQ{fill == 2'd3}} & ~(f0 ^ f1) & ~(f1 ^ f2);
`else
    assign s_src = norm;
    assign upd   = '1;
`endif

    // s_d_ok blocks a false edge from the reset value of s_d.
    always_comb begin
        s_nxt   = (upd & s_src) | (~upd & s);
        edge_c  = EDGE_M & s & ~s_d & s_d_ok & {NUM_IRQ{en_i}};
        cnt_nxt = '0;
        irq_nxt = '0;
        ovr_nxt = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (en_i && EDGE_M[i]) begin
                if (edge_c[i]) begin
                    cnt_nxt[i] = STRETCH_V;
                end else if (cnt[i] != '0) begin
                    cnt_nxt[i] = cnt[i] - CW'(1);
                end
            end
            irq_nxt[i] = EDGE_M[i] ? (cnt_nxt[i] != '0) : (s[i] & en_i);
            ovr_nxt[i] = (edge_c[i] & (cnt[i] != '0)) | (overrun_o[i] & ~ovr_clr_i[i]);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            s         <= '0;
            s_d       <= '0;
            s_ok      <= '0;
            s_d_ok    <= '0;
            cnt       <= '0;
            irq_o     <= '0;
            overrun_o <= '0;
        end else begin
            s         <= s_nxt;
            s_d       <= s;
            s_ok      <= s_ok | upd;
            s_d_ok    <= s_ok;
            cnt       <= cnt_nxt;
            irq_o     <= irq_nxt;
            overrun_o <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_irq_cond.sv
// Self-checking bench for irq_cond: directed scenarios plus random traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_irq_cond;

    localparam logic [31:0] EM   = 32'hABCD_0032;
    localparam logic [31:0] PM   = 32'h5A00_00A4;
    localparam int          STR  = 4;
    localparam logic [7:0]  EDGE_L = EM[7:0];
    localparam logic [7:0]  POL_L  = PM[7:0];
    localparam logic [7:0]  IDLE   = POL_L;
`ifdef IRQ_COND_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    logic       aclk;
    logic       areset;
    logic [7:0] irq;
    logic       en;
    logic [7:0] clr;
    logic [7:0] irq_o;
    logic [7:0] ovr;

    int n_chk = 0;
    int n_fail = 0;

    irq_cond #(.NUM_IRQ(8), .EDGE_MASK(EM), .POL_MASK(PM), .STRETCH(STR)) dut (
        .aclk(aclk), .areset(areset), .irq_i(irq), .en_i(en),
        .ovr_clr_i(clr), .irq_o(irq_o), .overrun_o(ovr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Model: sv/pv are the last two accepted samples (-1 = none since reset),
    // pend is the last cycle an edge-line pulse may be high.
    int tcur = 0;
    int sv[8];
    int pv[8];
    int pend[8];
    logic [7:0] m_irq = '0;
    logic [7:0] m_ovr = '0;
    logic [7:0] hq[$];
    logic [7:0] obs_i[80];
    logic [7:0] obs_o[80];

    task automatic model_step(input logic [7:0] raw, input logic e, input logic [7:0] c, input logic r);
        logic [7:0] nrm;
        logic [7:0] ni;
        logic [7:0] no;
        logic       edg;
        nrm = raw ^ POL_L;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                sv[i] = -1; pv[i] = -1; pend[i] = -1000000;
            end
            m_irq = '0;
            m_ovr = '0;
            hq.delete();
        end else begin
            for (int i = 0; i < 8; i++) begin
                edg = EDGE_L[i] && e && sv[i] == 1 && pv[i] == 0;
                no[i] = m_ovr[i];
                if (edg && m_irq[i]) no[i] = 1'b1;
                else if (c[i]) no[i] = 1'b0;
                if (!e) pend[i] = tcur;
                else if (edg) pend[i] = tcur + STR;
                ni[i] = EDGE_L[i] ? (e && (tcur + 1 <= pend[i])) : (e && sv[i] == 1);
                pv[i] = sv[i];
`ifdef IRQ_COND_GLITCH_FILTER_EN
                if (hq.size() == 3 && hq[0][i] == hq[1][i] && hq[1][i] == hq[2][i])
                    sv[i] = int'(hq[0][i]);
`else
                sv[i] = int'(nrm[i]);
`endif
            end
`ifdef IRQ_COND_GLITCH_FILTER_EN
            hq.push_back(nrm);
            if (hq.size() > 3) void'(hq.pop_front());
`endif
            m_irq = ni;
            m_ovr = no;
        end
        tcur++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h expected %h", name, tcur, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] raw, input logic e, input logic [7:0] c, input logic r, input int k);
        irq = raw; en = e; clr = c; areset = r;
        @(posedge aclk);
        model_step(raw, e, c, r);
        #1;
        chk("model irq_o", irq_o, m_irq);
        chk("model overrun_o", ovr, m_ovr);
        if (k + 1 < 80) begin
            obs_i[k + 1] = irq_o;
            obs_o[k + 1] = ovr;
        end
    endtask

    task automatic scen(input int id, input int n);
        logic [7:0] raw;
        logic [7:0] rraw;
        logic [7:0] cl;
        logic       e;
        logic       re;
        logic       r;
        rraw = IDLE;
        re = 1'b1;
        for (int c = 0; c < n; c++) begin
            raw = IDLE; e = 1'b1; cl = '0; r = (c < 2);
            case (id)
                0: begin
                    if (c >= 10 && c <= 19) raw[0] = 1'b1;
                    if (c >= 10 && c <= 59) raw[1] = 1'b1;
                    if (c >= 5 && c <= 7)   raw[2] = 1'b0;
                end
                1: begin
`ifdef IRQ_COND_GLITCH_FILTER_EN
                    if (c == 5 || c == 6 || (c >= 10 && c <= 12)) raw[0] = 1'b1;
`else
                    if (c == 10 || c == 11 || (c >= 13 && c <= 25)) raw[1] = 1'b1;
                    cl[1] = (c == 30);
`endif
                end
                2: begin
                    e = !(c >= 2 && c < 20);
                    raw[1] = (c >= 10);
                end
                3: begin
                    raw[1] = (c >= 10 && c <= 30) || c >= 35;
                    r = (c < 2) || (c == 11 + LAT);
                end
                default: begin
                    for (int b = 0; b < 8; b++)
                        if ($urandom_range(0, 4) == 0) rraw[b] = ~rraw[b];
                    if ($urandom_range(0, 19) == 0) re = ~re;
                    raw = rraw;
                    e = re;
                    cl = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
                    r = (c < 2) || ($urandom_range(0, 255) == 0);
                end
            endcase
            step(raw, e, cl, r, c);
        end
    endtask

    logic acc;

    initial begin
        areset = 1'b1; irq = IDLE; en = 1'b1; clr = '0;

        // Reset state
        step(IDLE, 1'b1, 8'h00, 1'b1, 0);
        chk("reset irq_o", irq_o, 8'h00);
        chk("reset overrun_o", ovr, 8'h00);

        // Level, edge, active-low level
        scen(0, 64);
        chk("lvl0 before", 8'(obs_i[9 + LAT][0]), 8'd0);
        chk("lvl0 first", 8'(obs_i[10 + LAT][0]), 8'd1);
        chk("lvl0 last", 8'(obs_i[19 + LAT][0]), 8'd1);
        chk("lvl0 after", 8'(obs_i[20 + LAT][0]), 8'd0);
        chk("edge1 before", 8'(obs_i[9 + LAT][1]), 8'd0);
        chk("edge1 first", 8'(obs_i[10 + LAT][1]), 8'd1);
        chk("edge1 last", 8'(obs_i[13 + LAT][1]), 8'd1);
        chk("edge1 after", 8'(obs_i[14 + LAT][1]), 8'd0);
        chk("edge1 no ovr", 8'(obs_o[63][1]), 8'd0);
        chk("pol2 before", 8'(obs_i[4 + LAT][2]), 8'd0);
        chk("pol2 first", 8'(obs_i[5 + LAT][2]), 8'd1);
        chk("pol2 last", 8'(obs_i[7 + LAT][2]), 8'd1);
        chk("pol2 after", 8'(obs_i[8 + LAT][2]), 8'd0);

        // Retrigger/overrun, or glitch rejection with the filter
        scen(1, 40);
`ifdef IRQ_COND_GLITCH_FILTER_EN
        acc = 1'b0;
        for (int k = 2; k <= 14; k++) acc |= obs_i[k][0];
        chk("glitch rejected", 8'(acc), 8'd0);
        chk("filt first", 8'(obs_i[15][0]), 8'd1);
        chk("filt last", 8'(obs_i[17][0]), 8'd1);
        chk("filt after", 8'(obs_i[18][0]), 8'd0);
`else
        chk("retrig before", 8'(obs_i[11][1]), 8'd0);
        chk("retrig first", 8'(obs_i[12][1]), 8'd1);
        chk("retrig last", 8'(obs_i[18][1]), 8'd1);
        chk("retrig after", 8'(obs_i[19][1]), 8'd0);
        chk("ovr set", 8'(obs_o[20][1]), 8'd1);
        chk("ovr held", 8'(obs_o[30][1]), 8'd1);
        chk("ovr cleared", 8'(obs_o[31][1]), 8'd0);
`endif

        // Rise while disabled produces nothing after enable
        scen(2, 45);
        acc = 1'b0;
        for (int k = 2; k <= 44; k++) acc |= obs_i[k][1];
        chk("en0 no pulse", 8'(acc), 8'd0);
        chk("en0 no ovr", 8'(obs_o[44][1]), 8'd0);

        // Reset mid-pulse, held line, then a genuine re-rise
        scen(3, 50);
        chk("rst pulse on", 8'(obs_i[10 + LAT][1]), 8'd1);
        chk("rst kills", 8'(obs_i[12 + LAT][1]), 8'd0);
        acc = 1'b0;
        for (int k = 12 + LAT; k <= 34 + LAT; k++) acc |= obs_i[k][1];
        chk("held no edge", 8'(acc), 8'd0);
        chk("re-rise pulse", 8'(obs_i[35 + LAT][1]), 8'd1);

        // Random traffic
        scen(4, 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
